// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } sram_state_e;

endpackage

// File: rtl/ahb_sram_array.sv
// WORDS x 32 synchronous SRAM, one registered read port and one byte-masked write port.
// A read and write to the same word in one cycle returns the old contents.
module ahb_sram_array #(
  parameter int WORDS = 1024,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wbe,
  input  logic [31:0]   wdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: programmable wait states, two-cycle ERROR response,
// write-to-read bypass so a read right after a write sees the merged word.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output sram_state_e dbg_state
);

  localparam int          AW         = $clog2(MEM_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;
  localparam logic [2:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  sram_state_e   state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic          addr_phase, accept, legal;
  logic          size_ok, align_ok, range_ok;
  logic [3:0]    lanes;
  logic          pend_valid, pend_write;
  logic [AW-1:0] pend_word;
  logic [3:0]    pend_be;
  logic          data_done, mem_we, mem_re;
  logic          byp_valid;
  logic [3:0]    byp_be;
  logic [31:0]   byp_data;
  logic [31:0]   arr_rdata;
  logic          unused_inputs;

  assign unused_inputs = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

  // Address phase decode: legality and write byte lanes
  always_comb begin
    size_ok  = (HSIZE <= HSIZE_WORD);
    range_ok = ({1'b0, HADDR} < ADDR_LIMIT);
    align_ok = 1'b1;
    lanes    = 4'b1111;
    case (HSIZE)
      HSIZE_BYTE: lanes = 4'b0001 << HADDR[1:0];
      HSIZE_HALF: begin
        align_ok = ~HADDR[0];
        lanes    = HADDR[1] ? 4'b1100 : 4'b0011;
      end
      HSIZE_WORD: align_ok = (HADDR[1:0] == 2'b00);
      default:    align_ok = 1'b0;
    endcase
  end

  assign legal      = size_ok & align_ok & range_ok;
  assign addr_phase = (state == ST_IDLE) || (state == ST_ERR2);
  assign accept     = HSEL & HREADY & HTRANS[1] & addr_phase;

  // A legal data phase ends in IDLE once the bus-wide HREADY is high
  assign data_done = pend_valid & HREADY & (state == ST_IDLE);
  assign mem_we    = data_done & pend_write & ~reset;
  assign mem_re    = accept & legal & ~HWRITE;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE, ST_ERR2: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (!legal) begin
            state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 3'd0) state_nxt = ST_IDLE;
        else             cnt_nxt   = cnt - 3'd1;
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= 3'd0;
      pend_valid <= 1'b0;
      pend_write <= 1'b0;
      pend_word  <= '0;
      pend_be    <= 4'd0;
      byp_valid  <= 1'b0;
      byp_be     <= 4'd0;
      byp_data   <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        pend_valid <= legal;
        pend_write <= HWRITE;
        pend_word  <= HADDR[AW+1:2];
        pend_be    <= lanes;
        // The array returns the pre-write word here; remember the lanes being written over it
        byp_valid  <= mem_we & ~HWRITE & (HADDR[AW+1:2] == pend_word);
        byp_be     <= pend_be;
        byp_data   <= HWDATA;
      end else if (data_done) begin
        pend_valid <= 1'b0;
      end
    end
  end

  ahb_sram_array #(.WORDS(MEM_WORDS)) u_array (
    .clk   (clk),
    .re    (mem_re),
    .raddr (HADDR[AW+1:2]),
    .rdata (arr_rdata),
    .we    (mem_we),
    .waddr (pend_word),
    .wbe   (pend_be),
    .wdata (HWDATA)
  );

  always_comb begin
    HRDATA = 32'd0;
    if (pend_valid && !pend_write) begin
      for (int b = 0; b < 4; b++) begin
        HRDATA[8*b +: 8] = (byp_valid && byp_be[b]) ? byp_data[8*b +: 8] : arr_rdata[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = ~((state == ST_WAIT) || (state == ST_ERR1));
  assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign dbg_state = state;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a three-wait instance share one AHB bus
// whose HREADY is the AND of both slaves, so both see identical traffic in lockstep.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam int MEM_WORDS = 1024;
  localparam int WAIT3     = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        hsel, hwrite, hmastlock, hready;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [31:0] hrdata0, hrdata3;
  logic        hreadyout0, hreadyout3, hresp0, hresp3;
  sram_state_e st0, st3;

  assign hready = hreadyout0 & hreadyout3;

  ahb_sram_slave #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
    .HREADY(hready), .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0), .dbg_state(st0)
  );

  ahb_sram_slave #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(WAIT3)) dut3 (
    .clk(clk), .reset(reset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata),
    .HREADY(hready), .HRDATA(hrdata3), .HREADYOUT(hreadyout3), .HRESP(hresp3), .dbg_state(st3)
  );

  // Scoreboard and reference model
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [MEM_WORDS];
  int          n_checks = 0;
  int          n_errors = 0;

  logic        dp_valid = 1'b0;
  logic        dp_write, dp_err;
  logic [31:0] dp_addr, dp_wdata;
  logic [2:0]  dp_size;
  int          low0, low3, resp_bad;
  logic [31:0] last_rdata0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic legal_ref(input logic [31:0] addr, input logic [2:0] size);
    longint unsigned a;
    a = addr;
    if (size > 3'd2) return 1'b0;
    if ((a % (64'd1 << size)) != 0) return 1'b0;
    return a < 4 * MEM_WORDS;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd);
    int word, lane;
    word = int'(addr / 4);
    for (int b = 0; b < (1 << size); b++) begin
      lane = int'(addr % 4) + b;
      model_mem[word][lane*8 +: 8] = wd[lane*8 +: 8];
    end
  endtask

  task automatic start_dp(input logic [31:0] addr, input logic [2:0] size, input logic wr,
                          input logic [31:0] wd);
    dp_valid = 1'b1;
    dp_write = wr;
    dp_addr  = addr;
    dp_size  = size;
    dp_wdata = wd;
    dp_err   = ~legal_ref(addr, size);
    low0 = 0; low3 = 0; resp_bad = 0;
    hwdata = wr ? wd : $urandom;
    if (!wr) exp_q.push_back(dp_err ? 32'd0 : model_mem[addr / 4]);
  endtask

  task automatic finish_dp();
    logic [31:0] e;
    check("low_cycles_ws0", low0, dp_err ? 32'd1 : 32'd0);
    check("low_cycles_ws3", low3, dp_err ? 32'd1 : WAIT3);
    check("hresp", resp_bad, 32'd0);
    if (!dp_write) begin
      e = exp_q.pop_front();
      check("hrdata_ws0", hrdata0, e);
      check("hrdata_ws3", hrdata3, e);
      last_rdata0 = hrdata0;
    end else if (!dp_err) begin
      model_write(dp_addr, dp_size, dp_wdata);
    end
    dp_valid = 1'b0;
  endtask

  // One bus cycle: present an address phase, let the current data phase finish, step the clock
  task automatic bus_cycle(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                           input logic [2:0] size, input logic wr, input logic [31:0] wd);
    int waits;
    hsel = sel; htrans = trans; haddr = addr; hsize = size; hwrite = wr;
    hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
    waits = 0;
    forever begin
      @(negedge clk);
      if (dp_valid) begin
        if (!hreadyout0) low0++;
        if (!hreadyout3) low3++;
        if (hresp0 !== dp_err || hresp3 !== dp_err) resp_bad++;
      end else begin
        check("idle_okay", {28'd0, hreadyout0, hreadyout3, hresp0, hresp3}, 32'hC);
      end
      if (hready) break;
      waits++;
      if (waits > 20) begin
        check("hready_timeout", waits, 32'd0);
        break;
      end
    end
    if (dp_valid) finish_dp();
    @(posedge clk); #1;
    if (sel && trans[1]) start_dp(addr, size, wr, wd);
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd);
    bus_cycle(1'b1, ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, addr, size, wr, wd);
  endtask

  task automatic flush();
    bus_cycle(1'b0, HTRANS_IDLE, 32'd0, HSIZE_WORD, 1'b0, 32'd0);
  endtask

  task automatic idle_random();
    case ($urandom_range(0, 2))
      0:       bus_cycle(1'b0, HTRANS_NONSEQ, $urandom, HSIZE_WORD, 1'($urandom), 32'd0);
      1:       bus_cycle(1'b1, HTRANS_BUSY, $urandom, HSIZE_WORD, 1'b1, 32'd0);
      default: bus_cycle(1'b1, HTRANS_IDLE, $urandom, HSIZE_WORD, 1'b1, 32'd0);
    endcase
  endtask

  function automatic logic [31:0] rand_word_addr();
    int w;
    w = ($urandom_range(0, 4) == 0) ? $urandom_range(MEM_WORDS - 4, MEM_WORDS - 1)
                                    : $urandom_range(0, 15);
    return 32'(w * 4);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, saved;
    logic [2:0]  sz;

    reset = 1'b1;
    hsel = 1'b0; htrans = HTRANS_IDLE; haddr = 32'd0; hsize = HSIZE_WORD; hwrite = 1'b0;
    hwdata = 32'd0; hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_readyout", {30'd0, hreadyout0, hreadyout3}, 32'h3);
    check("rst_hresp", {30'd0, hresp0, hresp3}, 32'h0);
    check("rst_hrdata0", hrdata0, 32'd0);
    check("rst_hrdata3", hrdata3, 32'd0);
    reset = 1'b0;

    // Give every word the bench touches a known value
    for (int w = 0; w < 16; w++) xfer(1'b1, 32'(w * 4), HSIZE_WORD, $urandom);
    for (int w = MEM_WORDS - 4; w < MEM_WORDS; w++) xfer(1'b1, 32'(w * 4), HSIZE_WORD, $urandom);
    flush();

    // Write then read the same word back-to-back
    xfer(1'b1, 32'h10, HSIZE_WORD, 32'hDEAD_BEEF);
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'd0);
    flush();
    check("bypass_word", last_rdata0, 32'hDEAD_BEEF);

    // Byte write into lane 3 over a full word, other lanes of HWDATA are noise
    xfer(1'b1, 32'h10, HSIZE_WORD, 32'h1122_3344);
    xfer(1'b1, 32'h13, HSIZE_BYTE, {8'hAA, 24'($urandom)});
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'd0);
    flush();
    check("byte_merge", last_rdata0, 32'hAA22_3344);

    // Illegal transfers followed by a read proving storage is untouched
    xfer(1'b1, 32'h01, HSIZE_HALF, 32'hFFFF_FFFF);
    xfer(1'b0, 32'h1000, HSIZE_WORD, 32'd0);
    xfer(1'b0, 32'h00, HSIZE_WORD, 32'd0);
    xfer(1'b1, 32'h04, 3'd3, 32'hFFFF_FFFF);
    xfer(1'b0, 32'h04, HSIZE_WORD, 32'd0);
    flush();

    // BUSY and deselected cycles between transfers
    xfer(1'b1, 32'h24, HSIZE_WORD, 32'h0BAD_F00D);
    idle_random();
    bus_cycle(1'b1, HTRANS_BUSY, 32'h24, HSIZE_WORD, 1'b1, 32'd0);
    bus_cycle(1'b0, HTRANS_NONSEQ, 32'h24, HSIZE_WORD, 1'b1, 32'd0);
    xfer(1'b0, 32'h24, HSIZE_WORD, 32'd0);
    flush();

    // Reset in the middle of a waited write
    saved = model_mem[8];
    xfer(1'b1, 32'h20, HSIZE_WORD, ~saved);
    hsel = 1'b0; htrans = HTRANS_IDLE; reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_readyout", {30'd0, hreadyout0, hreadyout3}, 32'h3);
    check("midrst_hresp", {30'd0, hresp0, hresp3}, 32'h0);
    check("midrst_hrdata3", hrdata3, 32'd0);
    check("midrst_state3", {30'd0, st3}, {30'd0, ST_IDLE});
    reset = 1'b0;
    dp_valid = 1'b0;
    xfer(1'b0, 32'h20, HSIZE_WORD, 32'd0);
    flush();
    check("midrst_word", last_rdata0, saved);

    // Randomised traffic with occasional errors and idle gaps
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        repeat ($urandom_range(1, 2)) idle_random();
      end
      sz = 3'($urandom_range(0, 2));
      a  = rand_word_addr() + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) sz = 3'd3;
      if ($urandom_range(0, 14) == 0) a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 2) != 0) a = a & ~((32'd1 << sz) - 1);
        xfer(1'b1, a, sz, $urandom);
      end else begin
        xfer(1'b0, a & ~32'd3, ($urandom_range(0, 7) == 0) ? sz : HSIZE_WORD, 32'd0);
      end
    end
    flush();
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter MEM_WORDS, default 1024: number of 32-bit words of backing storage (power of two).
REQ-002 Parameter WAIT_STATES, default 0, legal 0..7: HREADYOUT-low cycles inserted in every OKAY NONSEQ/SEQ data phase.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 HSEL  input  1  slave select from the decoder.
REQ-006 HADDR  input  32  byte address, address phase.
REQ-007 HTRANS  input  2  IDLE/BUSY/NONSEQ/SEQ.
REQ-008 HSIZE  input  3  transfer size, byte/half/word.
REQ-009 HWRITE  input  1  1 = write.
REQ-010 HBURST, HPROT, HMASTLOCK  input  3/4/1  accepted, functionally ignored.
REQ-011 HWDATA  input  32  write data, data phase.
REQ-012 HREADY  input  1  bus-wide ready; address phase sampled only when high.
REQ-013 HRDATA  output  32  read data, valid when HREADYOUT=1 in a read data phase.
REQ-014 HREADYOUT  output  1  slave ready.
REQ-015 HRESP  output  1  0 = OKAY, 1 = ERROR.

Function
REQ-016 Transfer accepted when HSEL & HREADY & HTRANS[1] at a rising edge; address, size, write and lane information registered.
REQ-017 IDLE/BUSY or unselected cycles produce a zero-wait OKAY response (HREADYOUT=1, HRESP=0).
REQ-018 Legal transfer: HSIZE<=2, HADDR aligned to size, HADDR < 4*MEM_WORDS; otherwise ERROR.
REQ-019 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-020 IDLE: on legal accept, go WAIT if WAIT_STATES>0 (load counter WAIT_STATES-1) else stay IDLE with a zero-wait data phase; on illegal accept go ERR1.
REQ-021 WAIT: HREADYOUT=0; decrement counter; when counter=0 next cycle is final data-phase cycle (HREADYOUT=1), then IDLE or new transfer per REQ-020.
REQ-022 ERR1: HREADYOUT=0, HRESP=1; always go ERR2.
REQ-023 ERR2: HREADYOUT=1, HRESP=1; accepts next address phase as in IDLE.
REQ-024 Errored transfer never modifies storage; errored read drives HRDATA=0.
REQ-025 Write byte lanes from HADDR[1:0] and HSIZE (byte: 1 lane, half: lanes 1:0 or 3:2, word: all); HWDATA sampled and committed at end of the final data-phase cycle only.
REQ-026 Read returns full 32-bit word at HADDR[31:2] with MEM_WORDS index wrap-free (out of range already ERROR); master extracts lanes.
REQ-027 Read data phase immediately following a write to the same word SHALL return merged new data (bypass), zero extra wait states.
REQ-028 Back-to-back transfers: next address phase accepted in same cycle as current final data-phase cycle; full throughput 1 transfer/cycle at WAIT_STATES=0.
REQ-029 HREADYOUT low SHALL never exceed WAIT_STATES cycles per OKAY transfer or 1 cycle per ERROR transfer.

Reset
REQ-030 While reset high: state IDLE, counter 0, pending transfer cleared, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-031 Reset mid-transfer abandons it; a pending write is not committed.
REQ-032 Storage contents are not reset.

Structure
REQ-033 Shared package ahb_pkg holds HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3), HSIZE encodings (BYTE=0, HALF=1, WORD=2), HRESP OKAY/ERROR, and the FSM state typedef.
REQ-034 One sub-module ahb_sram_array: MEM_WORDS x 32 synchronous array, per-byte write enables, one read and one write port.
REQ-035 Lane-decode and legality checks are combinational in ahb_sram_slave.

Verification
REQ-036 WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 back-to-back -> HREADYOUT never low, HRDATA=0xDEADBEEF via bypass.
REQ-037 Byte write 0xAA @0x13 over word 0x11223344 @0x10, then read @0x10 -> 0xAA223344.
REQ-038 WAIT_STATES=3: read @0x0 -> exactly 3 HREADYOUT-low cycles, then data with HRESP=0.
REQ-039 Half write @0x01 (misaligned) and word read @0x1000 with MEM_WORDS=1024 -> two-cycle ERROR each (HREADYOUT 0 then 1, HRESP 1 both), storage unchanged.
REQ-040 HTRANS=BUSY and HSEL=0 cycles interleaved between NONSEQ transfers -> zero-wait OKAY, no storage change.
REQ-041 Reset asserted during WAIT of a write @0x20 -> outputs return to reset values next cycle, word @0x20 unchanged.
